// File: rtl/cms_stream_packer_if.sv
// rtl/cms_stream_packer_if.sv - AXI-Stream handshake bundle used on both sides of the packer
// Signals: tvalid/tready handshake, tdata (DW bits), tlast packet end.
// Modports: master drives tvalid/tdata/tlast and samples tready; slave is the mirror.
interface cms_stream_packer_if #(
  parameter int DW = 64
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cms_stream_packer.sv
// rtl/cms_stream_packer.sv - packs (XLEN+32)-bit CMS trace items densely into a 64-bit stream
// Ports:
//   clk, rst_n    single clock, asynchronous active-low reset
//   S_AXIS        slave stream of trace items (PC + instruction), word 0 = tdata[31:0]
//   M_AXIS        master stream of 64-bit beats, low word first in stream order
//   M_AXIS_tkeep  byte enables, present only when CMS_PACKER_TKEEP_EN is defined
//   packets_out   number of beats sent with tlast, wraps at 2^32
// Optional feature macro: CMS_PACKER_TKEEP_EN
module cms_stream_packer #(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  cms_stream_packer_if.slave  S_AXIS,
  cms_stream_packer_if.master M_AXIS,
`ifdef CMS_PACKER_TKEEP_EN
  output logic [7:0]          M_AXIS_tkeep,
`endif
  output logic [31:0]         packets_out
);
  localparam int         WI   = (XLEN + 32) / 32;
  localparam logic [2:0] W    = 3'(WI);
  localparam logic [2:0] ROOM = 3'(4 - WI);

  logic [31:0] acc     [4];
  logic [31:0] acc_nxt [4];
  logic [2:0]  fill;
  logic [2:0]  fill_nxt;
  logic [2:0]  shift;
  logic [2:0]  base;
  logic        last_pending;
  logic        last_pending_nxt;
  logic        padded;
  logic        bfire;
  logic        ifire;

  // A lone word is only ever emitted as the zero-padded close of a packet.
  assign padded        = (fill == 3'd1);
  assign M_AXIS.tvalid = (fill >= 3'd2) | (last_pending & padded);
  assign M_AXIS.tdata  = padded ? {32'h0, acc[0]} : {acc[1], acc[0]};
  assign M_AXIS.tlast  = last_pending & (fill <= 3'd2);

`ifdef CMS_PACKER_TKEEP_EN
  assign M_AXIS_tkeep = !M_AXIS.tvalid ? 8'h00 : (padded ? 8'h0F : 8'hFF);
`endif

  assign bfire = M_AXIS.tvalid & M_AXIS.tready;
  assign shift = bfire ? (padded ? 3'd1 : 3'd2) : 3'd0;
  // base is the occupancy after this cycle's beat leaves; new words land there.
  assign base  = fill - shift;

  // Accepting only when the item fits above base keeps appends clear of
  // acc[0..1] while a beat is being presented, and holding off after tlast
  // keeps the accumulator to a single packet.
  assign S_AXIS.tready = !last_pending & (base <= ROOM);
  assign ifire         = S_AXIS.tvalid & S_AXIS.tready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_nxt[i] = 32'h0;
      if (i + int'(shift) < 4) begin
        acc_nxt[i] = acc[2'(i + int'(shift))];
      end
    end
    if (ifire) begin
      for (int j = 0; j < WI; j++) begin
        acc_nxt[2'(int'(base) + j)] = S_AXIS.tdata[32*j +: 32];
      end
    end
  end

  always_comb begin
    fill_nxt         = base + (ifire ? W : 3'd0);
    last_pending_nxt = last_pending;
    if (bfire && M_AXIS.tlast) begin
      last_pending_nxt = 1'b0;
    end
    if (ifire && S_AXIS.tlast) begin
      last_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill         <= 3'd0;
      last_pending <= 1'b0;
      packets_out  <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= 32'h0;
      end
    end else begin
      fill         <= fill_nxt;
      last_pending <= last_pending_nxt;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= acc_nxt[i];
      end
      if (bfire && M_AXIS.tlast) begin
        packets_out <= packets_out + 32'd1;
      end
    end
  end
endmodule
